// File: rtl/cpu_pkg.sv
// Shared encodings for the instruction controller: states, instruction classes,
// field layout and the datapath select/ALU codes.
package cpu_pkg;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_IN = 2'b01;
  localparam logic [1:0] VSEL_C  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG
  } state_t;

  typedef enum logic [2:0] {
    CLS_MOV_IMM, CLS_MOV_REG, CLS_ADD, CLS_CMP, CLS_AND, CLS_MVN, CLS_ILLEGAL
  } iclass_t;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
  } fields_t;

endpackage

// File: rtl/cpu_controller_if.sv
// Control bus from the instruction controller to the 16-bit datapath.
interface cpu_controller_if #(parameter int DATA_W = 16);
  logic [DATA_W-1:0] datapath_in;
  logic [1:0]        vsel;
  logic [2:0]        readnum;
  logic [2:0]        writenum;
  logic              write;
  logic              loada;
  logic              loadb;
  logic              loadc;
  logic              loads;
  logic              asel;
  logic              bsel;
  logic [1:0]        shift;
  logic [1:0]        ALUop;

  modport master (
    output datapath_in, vsel, readnum, writenum, write,
           loada, loadb, loadc, loads, asel, bsel, shift, ALUop
  );

  modport slave (
    input datapath_in, vsel, readnum, writenum, write,
          loada, loadb, loadc, loads, asel, bsel, shift, ALUop
  );
endinterface

// File: rtl/instr_decoder.sv
// Combinational split of the instruction register into fields, the
// sign-extended immediate and the instruction class.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       ir,
  output fields_t           fields,
  output logic [DATA_W-1:0] imm,
  output iclass_t           iclass
);

  assign fields = '{op: ir[12:11], rn: ir[10:8], rd: ir[7:5], sh: ir[4:3], rm: ir[2:0]};
  assign imm    = {{(DATA_W-8){ir[7]}}, ir[7:0]};

  always_comb begin
    // NOTE: default first so every path assigns iclass and no latch is inferred.
    iclass = CLS_ILLEGAL;
    if (ir[15:13] == OPC_MOV) begin
      if (ir[12:11] == OP_MOV_IMM)      iclass = CLS_MOV_IMM;
      else if (ir[12:11] == OP_MOV_REG) iclass = CLS_MOV_REG;
    end else if (ir[15:13] == OPC_ALU) begin
      unique case (ir[12:11])
        OP_ADD:  iclass = CLS_ADD;
        OP_CMP:  iclass = CLS_CMP;
        OP_AND:  iclass = CLS_AND;
        default: iclass = CLS_MVN;
      endcase
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register, retired counter and Moore FSM that sequences the
// register file, A/B/C, shifter, ALU and status register of the datapath.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] instr,
  output logic        w,
  output logic        illegal,
  output logic [15:0] retired,
  cpu_controller_if.master dp
);

  state_t            state, state_next;
  logic [15:0]       ir;
  fields_t           f;
  logic [DATA_W-1:0] imm;
  iclass_t           cls;
  logic              retire;

  instr_decoder #(.DATA_W(DATA_W)) u_dec (
    .ir     (ir),
    .fields (f),
    .imm    (imm),
    .iclass (cls)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_WAIT;
      ir      <= '0;
      retired <= '0;
    end else begin
      state <= state_next;
      if (state == S_WAIT && load) ir <= instr;
      if (retire) retired <= retired + 16'd1;
    end
  end

  assign dp.datapath_in = imm;
  assign dp.bsel        = 1'b0;

  always_comb begin
    state_next  = state;
    retire      = 1'b0;
    w           = 1'b0;
    illegal     = 1'b0;
    dp.vsel     = VSEL_C;
    dp.readnum  = 3'd0;
    dp.writenum = 3'd0;
    dp.write    = 1'b0;
    dp.loada    = 1'b0;
    dp.loadb    = 1'b0;
    dp.loadc    = 1'b0;
    dp.loads    = 1'b0;
    dp.asel     = 1'b0;
    dp.shift    = 2'b00;
    dp.ALUop    = ALU_ADD;

    unique case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_next = S_DECODE;
      end
      S_DECODE: begin
        unique case (cls)
          CLS_MOV_IMM:                 state_next = S_WRITE_IMM;
          CLS_ADD, CLS_CMP, CLS_AND:   state_next = S_GET_A;
          CLS_MOV_REG, CLS_MVN:        state_next = S_GET_B;
          default: begin
            illegal    = 1'b1;
            state_next = S_WAIT;
          end
        endcase
      end
      S_WRITE_IMM: begin
        dp.writenum = f.rn;
        dp.vsel     = VSEL_IN;
        dp.write    = 1'b1;
        retire      = 1'b1;
        state_next  = S_WAIT;
      end
      S_GET_A: begin
        dp.readnum = f.rn;
        dp.loada   = 1'b1;
        state_next = S_GET_B;
      end
      S_GET_B: begin
        dp.readnum = f.rm;
        dp.loadb   = 1'b1;
        dp.shift   = f.sh;
        state_next = S_ALU;
      end
      S_ALU: begin
        dp.shift = f.sh;
        dp.loads = 1'b1;
        // MOV Rd,Rm is computed as 0 + shifted Rm through the adder.
        if (cls == CLS_MOV_REG) begin
          dp.ALUop = ALU_ADD;
          dp.asel  = 1'b1;
        end else begin
          dp.ALUop = f.op;
        end
        if (cls == CLS_CMP) begin
          retire     = 1'b1;
          state_next = S_WAIT;
        end else begin
          dp.loadc   = 1'b1;
          state_next = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        dp.writenum = f.rd;
        dp.vsel     = VSEL_C;
        dp.write    = 1'b1;
        retire      = 1'b1;
        state_next  = S_WAIT;
      end
      default: state_next = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench: cpu_controller driving a small behavioural datapath model;
// checks register file, status, latency and per-state control outputs.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s = 1'b0;
  logic        load = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        w;
  logic        illegal;
  logic [15:0] retired;

  int total = 0;
  int bad   = 0;

  cpu_controller_if #(.DATA_W(16)) dp ();

  cpu_controller #(.DATA_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s       (s),
    .load    (load),
    .instr   (instr),
    .w       (w),
    .illegal (illegal),
    .retired (retired),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: regfile, A/B/C, shifter, ALU, Z/N/V status.
  logic [15:0] rf [0:7] = '{default: 16'h0000};
  logic [15:0] ra = 16'h0, rb = 16'h0, rc = 16'h0;
  logic        z = 1'b0, n = 1'b0, v = 1'b0;
  logic [15:0] sout, ain, bin, aout;
  logic        vout;

  always_comb begin
    case (dp.shift)
      2'b00:   sout = rb;
      2'b01:   sout = {rb[14:0], 1'b0};
      2'b10:   sout = {1'b0, rb[15:1]};
      default: sout = {rb[15], rb[15:1]};
    endcase
    ain = dp.asel ? 16'h0000 : ra;
    bin = dp.bsel ? dp.datapath_in : sout;
    vout = 1'b0;
    case (dp.ALUop)
      2'b00: begin
        aout = ain + bin;
        vout = (ain[15] == bin[15]) && (aout[15] != ain[15]);
      end
      2'b01: begin
        aout = ain - bin;
        vout = (ain[15] != bin[15]) && (aout[15] != ain[15]);
      end
      2'b10:   aout = ain & bin;
      default: aout = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (dp.write) rf[dp.writenum] <= (dp.vsel == 2'b01) ? dp.datapath_in : rc;
    if (dp.loada) ra <= rf[dp.readnum];
    if (dp.loadb) rb <= rf[dp.readnum];
    if (dp.loadc) rc <= aout;
    if (dp.loads) begin
      z <= (aout == 16'h0000);
      n <= aout[15];
      v <= vout;
    end
  end

  function automatic logic [19:0] ctl_vec();
    return {w, dp.write, dp.loada, dp.loadb, dp.loadc, dp.loads, dp.asel,
            dp.vsel, dp.readnum, dp.writenum, dp.shift, dp.ALUop};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load word, start it, and count cycles from the start edge until WAIT.
  task automatic issue(input logic [15:0] word, output int cycles);
    load = 1'b1; instr = word; s = 1'b0;
    step();
    load = 1'b0; s = 1'b1;
    step();
    s = 1'b0;
    cycles = 1;
    while (w !== 1'b1 && cycles < 20) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if (ctl_vec() !== {1'b1, 6'b0, 2'b11, 3'd0, 3'd0, 2'b00, 2'b00}) begin
      bad++;
      $display("FAIL reset_ctl: got %h expected %h", ctl_vec(),
               {1'b1, 6'b0, 2'b11, 3'd0, 3'd0, 2'b00, 2'b00});
    end
    total++;
    if (retired !== 16'h0000 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL reset_cnt: retired=%h illegal=%b expected 0000/0", retired, illegal);
    end
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_mov_imm();
    int cyc;
    issue(16'hD7FF, cyc);
    total++;
    if (cyc !== 3) begin bad++; $display("FAIL mov_latency: got %0d expected 3", cyc); end
    total++;
    if (rf[7] !== 16'hFFFF) begin bad++; $display("FAIL mov_r7: got %h expected ffff", rf[7]); end
    total++;
    if (w !== 1'b1 || retired !== 16'd1) begin
      bad++; $display("FAIL mov_done: w=%b retired=%0d expected 1/1", w, retired);
    end
  endtask

  task automatic test_add();
    int cyc;
    logic [19:0] exp_ctl [0:5];
    exp_ctl[0] = {1'b0, 6'b000000, 2'b11, 3'd0, 3'd0, 2'b00, 2'b00};
    exp_ctl[1] = {1'b0, 6'b010000, 2'b11, 3'd0, 3'd0, 2'b00, 2'b00};
    exp_ctl[2] = {1'b0, 6'b001000, 2'b11, 3'd1, 3'd0, 2'b01, 2'b00};
    exp_ctl[3] = {1'b0, 6'b000110, 2'b11, 3'd0, 3'd0, 2'b01, 2'b00};
    exp_ctl[4] = {1'b0, 6'b100000, 2'b11, 3'd0, 3'd2, 2'b00, 2'b00};
    exp_ctl[5] = {1'b1, 6'b000000, 2'b11, 3'd0, 3'd0, 2'b00, 2'b00};
    issue(16'hD008, cyc);
    issue(16'hD103, cyc);
    total++;
    if (rf[0] !== 16'h0008 || rf[1] !== 16'h0003) begin
      bad++; $display("FAIL mov_r0_r1: got %h/%h expected 0008/0003", rf[0], rf[1]);
    end
    load = 1'b1; instr = 16'hA049;
    step();
    load = 1'b0; s = 1'b1;
    step();
    // Inputs held active mid-instruction must be ignored.
    load = 1'b1; instr = 16'hE000;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin load = 1'b0; s = 1'b0; instr = 16'h0000; end
      total++;
      if (ctl_vec() !== exp_ctl[i]) begin
        bad++; $display("FAIL add_state%0d: got %h expected %h", i, ctl_vec(), exp_ctl[i]);
      end
      if (i < 5) step();
    end
    total++;
    if (rf[2] !== 16'h000E) begin bad++; $display("FAIL add_r2: got %h expected 000e", rf[2]); end
    total++;
    if ({z, n, v} !== 3'b000) begin bad++; $display("FAIL add_znv: got %b expected 000", {z, n, v}); end
    total++;
    if (retired !== 16'd4) begin bad++; $display("FAIL add_retired: got %0d expected 4", retired); end
  endtask

  task automatic test_cmp();
    int cyc;
    issue(16'hAF07, cyc);
    total++;
    if (cyc !== 5) begin bad++; $display("FAIL cmp_latency: got %0d expected 5", cyc); end
    total++;
    if (z !== 1'b1 || rc !== 16'h000E) begin
      bad++; $display("FAIL cmp_flags: z=%b c=%h expected 1/000e", z, rc);
    end
    total++;
    if (rf[7] !== 16'hFFFF || rf[2] !== 16'h000E || rf[0] !== 16'h0008) begin
      bad++; $display("FAIL cmp_nowrite: r7=%h r2=%h r0=%h expected ffff/000e/0008", rf[7], rf[2], rf[0]);
    end
  endtask

  task automatic test_mvn();
    int cyc;
    issue(16'hB860, cyc);
    total++;
    if (cyc !== 5) begin bad++; $display("FAIL mvn_latency: got %0d expected 5", cyc); end
    total++;
    if (rf[3] !== 16'hFFF7) begin bad++; $display("FAIL mvn_r3: got %h expected fff7", rf[3]); end
    total++;
    if (retired !== 16'd6) begin bad++; $display("FAIL mvn_retired: got %0d expected 6", retired); end
  endtask

  task automatic test_illegal();
    load = 1'b1; instr = 16'hE000;
    step();
    load = 1'b0; s = 1'b1;
    step();
    s = 1'b0;
    total++;
    if (illegal !== 1'b1 || w !== 1'b0) begin
      bad++; $display("FAIL illegal_pulse: illegal=%b w=%b expected 1/0", illegal, w);
    end
    step();
    total++;
    if (illegal !== 1'b0 || w !== 1'b1 || retired !== 16'd6) begin
      bad++; $display("FAIL illegal_after: illegal=%b w=%b retired=%0d expected 0/1/6", illegal, w, retired);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    load = 1'b1; instr = 16'hA0A1;
    step();
    load = 1'b0; s = 1'b1;
    step();
    s = 1'b0;
    step(); step();
    total++;
    if (dp.loadb !== 1'b1 || dp.readnum !== 3'd1) begin
      bad++; $display("FAIL abort_getb: loadb=%b readnum=%0d expected 1/1", dp.loadb, dp.readnum);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ctl_vec() !== {1'b1, 6'b0, 2'b11, 3'd0, 3'd0, 2'b00, 2'b00} || retired !== 16'd0) begin
      bad++; $display("FAIL abort_reset: ctl=%h retired=%0d expected %h/0", ctl_vec(), retired,
                      {1'b1, 6'b0, 2'b11, 3'd0, 3'd0, 2'b00, 2'b00});
    end
    step(); step();
    rst_n = 1'b1;
    load = 1'b1; s = 1'b1; instr = 16'hD405;
    step();
    load = 1'b0; s = 1'b0;
    cyc = 1;
    while (w !== 1'b1 && cyc < 20) begin step(); cyc++; end
    step(); step();
    total++;
    if (cyc !== 3 || rf[4] !== 16'h0005 || retired !== 16'd1) begin
      bad++; $display("FAIL load_and_start: cyc=%0d r4=%h retired=%0d expected 3/0005/1", cyc, rf[4], retired);
    end
    total++;
    if (rf[5] !== 16'h0000) begin bad++; $display("FAIL abort_nowrite: r5=%h expected 0000", rf[5]); end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_mvn();
    test_illegal();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
